multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle control sequencer that steps the processor datapath through FETCH, DECODE, EXEC, MEM and WB, one state per cycle or longer. It sits between the combinational instruction decoder and the datapath. It consumes the decoder's per-instruction signals and turns them into time-qualified strobes: instruction-register load, memory requests, register-file write and PC write. It also owns instruction- and data-memory handshakes, halt detection, a bus-timeout error trap and optional performance counters.

## Interface
- `CNT_W`, 32: width of performance counters.
- `MEM_TIMEOUT`, 16: max consecutive no-ack cycles tolerated in FETCH or MEM; legal range 2..255.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: leaves IDLE when high; ignored in all other states.
- `imem_ack` in 1: instruction memory data valid.
- `dmem_ack` in 1: data memory access complete.
- `dec_wr_reg`, `dec_rd_mem`, `dec_wr_mem`, `dec_upd_pc` in 1 each: decoder outputs; stable from DECODE through WB.
- `imem_req` out 1: instruction fetch request.
- `ir_load` out 1: load the instruction register.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write qualifier.
- `rf_we` out 1: register-file write strobe.
- `pc_we` out 1: PC update strobe (next-PC/branch mux selected in datapath).
- `busy` out 1: state is not IDLE, HALT or ERR.
- `halted` out 1: state is HALT.
- `err` out 1: state is ERR.
- `state` out 3: current state encoding.
- `cycle_cnt` out CNT_W: active-cycle counter.
- `instret_cnt` out CNT_W: retired-instruction counter.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- **IDLE**: when `start`=1, go to FETCH.
- **FETCH**: `imem_req`=1. In a cycle with `imem_ack`=1, `ir_load`=1 (Mealy) and the next state is DECODE.
- **DECODE**: one cycle. If `dec_upd_pc`=0, go to HALT (no PC/RF write). Otherwise go to EXEC.
- **EXEC**: one cycle. If `dec_rd_mem` or `dec_wr_mem` is set, go to MEM; otherwise go to WB.
- **MEM**: `dmem_req`=1 and `dmem_we`=`dec_wr_mem`. On `dmem_ack`=1, go to WB.
- **WB**: one cycle. `rf_we`=`dec_wr_reg`, `pc_we`=1, then go to FETCH.
- **HALT** and **ERR** are terminal. Only `rst` exits them.
- All strobes are 0 outside the states listed above.
- **Timeout**:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle in which the ack is low.
  - If the ack is low while the counter equals `MEM_TIMEOUT`-1, the next state is ERR (after exactly `MEM_TIMEOUT` no-ack cycles).
  - An ack arriving in that same cycle wins: it is a normal transition, not ERR.
- Decoder inputs are sampled only in DECODE, EXEC, MEM and WB. Their values in other states are don't-care.

## Timing
- Reset (async assert): state=IDLE, all outputs 0, counters 0, wait counter 0.
- Reset mid-instruction aborts immediately. No partial `rf_we`/`pc_we` is issued after `rst` rises.
- Latency with zero-wait memories (ack in first FETCH/MEM cycle):
  - ALU/branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- `pc_we` is a single-cycle pulse per retired instruction.
- `ir_load` pulses once per fetch.
- `rf_we` is never high in the same cycle as `dmem_req`.
- `start` held high continuously has no effect after leaving IDLE.

## Configuration
- `PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle with `busy`=1.
  - `instret_cnt` increments in each WB cycle.
  - Both counters wrap modulo 2^CNT_W and clear only on `rst`.
- `PERF_CNT_EN` undefined: both counter outputs are tied to 0 and no counter flops exist. Sequencing is identical.

## Test plan
- Reset, `start` pulse, ALU instruction (`dec_wr_reg`=1, `dec_upd_pc`=1), acks immediate -> states 1,2,3,5,1; `ir_load` in cycle 1, `rf_we`=`pc_we`=1 in cycle 4; `instret_cnt`=1, `cycle_cnt`=4.
- Store (`dec_wr_mem`=1), `dmem_ack` delayed 3 cycles -> `dmem_req`=`dmem_we`=1 for 4 cycles, `rf_we`=0 in WB, `pc_we`=1; instruction takes 8 cycles.
- `dec_upd_pc`=0 in DECODE -> HALT next cycle, `halted`=1, `pc_we` never asserted, `start` ignored, counters freeze.
- `imem_ack` stuck low, `MEM_TIMEOUT`=16 -> ERR after 16 FETCH cycles, `err`=1. Repeat with ack in the 16th cycle -> DECODE, `err`=0.
- Assert `rst` during MEM of a load -> same-cycle state=0, all strobes 0, counters 0. A new `start` runs normally.
- With `PERF_CNT_EN`, `CNT_W`=4: run 5 ALU instructions -> `cycle_cnt` wraps to 4 (20 mod 16), `instret_cnt`=5.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Bus bundle between the multicycle control sequencer and its surroundings
// (instruction decoder, datapath, instruction/data memories).
//
// Handshake semantics: imem_req / dmem_req are held high for every cycle the
// sequencer is waiting in FETCH / MEM; the access completes in the cycle the
// matching ack is high, and the request drops (or the next access starts) on
// the following cycle. Acks seen outside FETCH / MEM are ignored.
//
// Modports:
//   master : the sequencer (drives requests, strobes, status, counters)
//   slave  : the environment (drives start, acks, decoder outputs)
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             imem_ack;
  logic             dmem_ack;
  logic             dec_wr_reg;
  logic             dec_rd_mem;
  logic             dec_wr_mem;
  logic             dec_upd_pc;
  logic             imem_req;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  logic             pc_we;
  logic             busy;
  logic             halted;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  start, imem_ack, dmem_ack,
    input  dec_wr_reg, dec_rd_mem, dec_wr_mem, dec_upd_pc,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we,
    output busy, halted, err, state, cycle_cnt, instret_cnt
  );

  modport slave (
    output start, imem_ack, dmem_ack,
    output dec_wr_reg, dec_rd_mem, dec_wr_mem, dec_upd_pc,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we,
    input  busy, halted, err, state, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps the datapath through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, turning the decoder's
// per-instruction flags into time-qualified strobes. Owns the memory
// handshakes, halt detection and a bus-timeout trap (ERR).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : multicycle_sequencer_if.master (start, acks, decoder flags in;
//          imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, busy,
//          halted, err, state, cycle_cnt, instret_cnt out)
//
// Parameters:
//   CNT_W       : performance counter width
//   MEM_TIMEOUT : consecutive no-ack cycles tolerated in FETCH/MEM (2..255)
//
// Build option: define PERF_CNT_EN to get the cycle / retired-instruction
// counters; otherwise both counter outputs are constant 0.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.pc_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        // An ack on the last allowed cycle still completes normally.
        if (bus.imem_ack) begin
          bus.ir_load = 1'b1;
          state_d     = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        // An instruction that does not advance the PC is the halt marker.
        state_d = bus.dec_upd_pc ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = (bus.dec_rd_mem || bus.dec_wr_mem) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = bus.dec_wr_mem;
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        bus.rf_we = bus.dec_wr_reg;
        bus.pc_we = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Each new memory wait window starts counting from zero.
    if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q)) begin
      wait_d = 8'd0;
    end
  end

  assign bus.state  = state_q;
  assign bus.busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
  assign bus.halted = (state_q == S_HALT);
  assign bus.err    = (state_q == S_ERR);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (bus.busy)         cycle_q   <= cycle_q + 1'b1;
      if (state_q == S_WB)  instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule
